// File: rtl/gh_pkg.sv
// Shared Streebog (GOST R 34.11-2012) definitions.
//   PI      : byte substitution table used by the S transform.
//   GH_A    : 64x64 binary matrix rows used by the L transform.
//   gh_state_t : 512-bit state viewed as 64 bytes; logical byte n lives at
//                packed index [63-n], i.e. bits [511-8n -: 8].
package gh_pkg;

  localparam int unsigned GH_STATE_W = 512;
  localparam int unsigned GH_BYTES   = 64;

  typedef logic [63:0][7:0] gh_state_t;

  localparam logic [7:0] PI [0:255] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // Row i is XORed into the L output when bit (63-i) of the input word is set.
  localparam logic [63:0] GH_A [0:63] = '{
    64'h8e20faa72ba0b470, 64'h47107ddd9b505a38, 64'had08b0e0c3282d1c, 64'hd8045870ef14980e,
    64'h6c022c38f90a4c07, 64'h3601161cf205268d, 64'h1b8e0b0e798c13c8, 64'h83478b07b2468764,
    64'ha011d380818e8f40, 64'h5086e740ce47c920, 64'h2843fd2067adea10, 64'h14aff010bdd87508,
    64'h0ad97808d06cb404, 64'h05e23c0468365a02, 64'h8c711e02341b2d01, 64'h46b60f011a83988e,
    64'h90dab52a387ae76f, 64'h486dd4151c3dfdb9, 64'h24b86a840e90f0d2, 64'h125c354207487869,
    64'h092e94218d243cba, 64'h8a174a9ec8121e5d, 64'h4585254f64090fa0, 64'haccc9ca9328a8950,
    64'h9d4df05d5f661451, 64'hc0a878a0a1330aa6, 64'h60543c50de970553, 64'h302a1e286fc58ca7,
    64'h18150f14b9ec46dd, 64'h0c84890ad27623e0, 64'h0642ca05693b9f70, 64'h0321658cba93c138,
    64'h86275df09ce8aaa8, 64'h439da0784e745554, 64'hafc0503c273aa42a, 64'hd960281e9d1d5215,
    64'he230140fc0802984, 64'h71180a8960409a42, 64'hb60c05ca30204d21, 64'h5b068c651810a89e,
    64'h456c34887a3805b9, 64'hac361a443d1c8cd2, 64'h561b0d22900e4669, 64'h2b838811480723ba,
    64'h9bcf4486248d9f5d, 64'hc3e9224312c8c1a0, 64'heffa11af0964ee50, 64'hf97d86d98a327728,
    64'he4fa2054a80b329c, 64'h727d102a548b194e, 64'h39b008152acb8227, 64'h9258048415eb419d,
    64'h492c024284fbaec0, 64'haa16012142f35760, 64'h550b8e9e21f7a530, 64'ha48b474f9ef5dc18,
    64'h70a6a56e2440598e, 64'h3853dc371220a247, 64'h1ca76e95091051ad, 64'h0edd37c48a08a6d8,
    64'h07e095624504536c, 64'h8d70c431ac02a736, 64'hc83862965601dd1b, 64'h641c314b2b8ee083
  };

endpackage

// File: rtl/gh_round_xsp_stage_sp_comb.sv
// Combinational S then P of the Streebog round.
//   x_i : 512-bit state after X
//   y_o : P(S(x_i)); output byte 8r+c = PI[input byte 8c+r]
module gh_sp_comb
  import gh_pkg::*;
(
  input  logic [GH_STATE_W-1:0] x_i,
  output logic [GH_STATE_W-1:0] y_o
);

  gh_state_t x_b;
  gh_state_t y_b;

  assign x_b = x_i;
  assign y_o = y_b;

  // Logical byte n sits at packed index GH_BYTES-1-n.
  always_comb begin
    y_b = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        y_b[GH_BYTES-1-(8*r+c)] = PI[x_b[GH_BYTES-1-(8*c+r)]];
      end
    end
  end

endmodule

// File: rtl/gh_round_xsp_stage.sv
// Streebog round X/S/P stage, two-deep valid/ready pipeline feeding the L stage.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   in_valid_i/in_ready_o : input handshake for in_state_i, in_key_i, in_tag_i
//   out_valid_o/out_ready_i : output handshake for out_state_o, out_tag_o
// Stage 1 registers state^key; stage 2 registers S+P of that.
module gh_round_xsp_stage
  import gh_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [GH_STATE_W-1:0] in_state_i,
  input  logic [GH_STATE_W-1:0] in_key_i,
  input  logic [TAG_W-1:0]      in_tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [GH_STATE_W-1:0] out_state_o,
  output logic [TAG_W-1:0]      out_tag_o
);

  logic                  v1_q, v1_d, v2_q, v2_d;
  gh_state_t             x1_q, x1_d, y2_q, y2_d;
  logic [TAG_W-1:0]      t1_q, t1_d, t2_q, t2_d;
  logic                  rdy1, rdy2;
  logic [GH_STATE_W-1:0] sp_y;

  // A stage may advance when it is empty or the stage after it is draining.
  assign rdy2 = !v2_q || out_ready_i;
  assign rdy1 = !v1_q || rdy2;

  gh_sp_comb u_sp (
    .x_i (x1_q),
    .y_o (sp_y)
  );

  always_comb begin
    v1_d = v1_q;
    x1_d = x1_q;
    t1_d = t1_q;
    v2_d = v2_q;
    y2_d = y2_q;
    t2_d = t2_q;
    if (rdy1) begin
      v1_d = in_valid_i;
      if (in_valid_i) begin
        x1_d = in_state_i ^ in_key_i;
        t1_d = in_tag_i;
      end
    end
    if (rdy2) begin
      v2_d = v1_q;
      if (v1_q) begin
        y2_d = sp_y;
        t2_d = t1_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q <= 1'b0;
      x1_q <= '0;
      t1_q <= '0;
      v2_q <= 1'b0;
      y2_q <= '0;
      t2_q <= '0;
    end else begin
      v1_q <= v1_d;
      x1_q <= x1_d;
      t1_q <= t1_d;
      v2_q <= v2_d;
      y2_q <= y2_d;
      t2_q <= t2_d;
    end
  end

  assign in_ready_o  = rdy1;
  assign out_valid_o = v2_q;
  assign out_state_o = y2_q;
  assign out_tag_o   = t2_q;

endmodule

// File: doc/gh_round_xsp_stage.md
Name: gh_round_xsp_stage

Overview:
Upstream neighbour of the Streebog round L (MixColumns) stage. It performs X (512-bit XOR of state with round key), then S (byte-wise π substitution), then P (8x8 byte transpose). It is a 2-stage valid/ready pipeline. The output feeds the L stage; the integrator drives the L stage's clken as out_valid & out_ready.

Parameters:
TAG_W, 4, width of the sideband tag (round index) carried alongside each state.

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_state/in_key/in_tag valid
in_ready  output  1  stage accepts input this cycle
in_state  input  512  state before X
in_key  input  512  round key K_i
in_tag  input  TAG_W  sideband, passed through unchanged
out_valid  output  1  out_state valid
out_ready  input  1  downstream accepts this cycle
out_state  output  512  P(S(X(state,key))), to the L stage's after_p input
out_tag  output  TAG_W  tag aligned with out_state

Behaviour:
- Byte numbering: logical byte n (0..63) = bits [511-8n -: 8]. Byte n=8r+c is row r, column c.
- Stage 1 register (v1, x1, t1): x1 <= in_state ^ in_key.
- Stage 2 register (v2, y2, t2): for every n, s[n] = PI[x1[n]]; y2[8r+c] <= s[8c+r].
- out_state = y2, out_tag = t2, out_valid = v2.
- Latency: an accepted input appears on out_valid exactly 2 cycles later if out_ready was never low.
- Throughput: 1 state per cycle with out_ready held high.
- Ready chain (combinational):
  - rdy2 = !v2 | out_ready
  - rdy1 = !v1 | rdy2
  - in_ready = rdy1
- Transfers:
  - Input accept: in_valid & in_ready.
  - Output accept: v2 & out_ready.
- Stage-1 update: when rdy1, v1 <= in_valid and x1/t1 load. When !rdy1, hold.
- Stage-2 update: when rdy2, v2 <= v1 and y2/t2 load. When !rdy2, hold.
- Stall: with out_ready low, data, tag and valid stay frozen. No bubble is inserted and no data is lost. At most 2 items are buffered, then in_ready = 0.
- Simultaneous accept and output with both stages full: the pipeline advances by one; in_ready = 1 in that cycle.
- Data registers load only on their stage-advance enable, never on invalid data.
- Reset (synchronous, any cycle, including mid-stall):
  - v1 = v2 = 0, x1 = y2 = 0, t1 = t2 = 0.
  - Hence out_valid = 0, out_state = 0, out_tag = 0, in_ready = 1 in the cycle after rst.
  - Items in flight are discarded.
  - rst has priority over every enable.
- out_valid never depends combinationally on out_ready. in_ready depends combinationally on out_ready only.

Decomposition:
- Shared package gh_pkg:
  - PI[0:255] byte table from GOST R 34.11-2012.
  - typedef gh_state_t = logic [63:0][7:0].
  - localparams GH_STATE_W = 512 and GH_BYTES = 64.
  - The L-stage matrix A moves here too for reuse.
- One sub-module, gh_sp_comb: combinational S+P, x[511:0] -> y[511:0]. Instantiated between x1 and the y2 register; unit-testable on its own.
- Pipeline control stays in the top module.

Test Plan:
- Zero vector: in_state = 0, in_key = 0, tag = 3 -> after 2 cycles out_state = 64 bytes of 0xFC, out_tag = 3, out_valid pulses for 1 cycle.
- X cancel and π top byte: in_state = in_key = 0x5A..5A -> all 0xFC. in_state = all 0xFF, key = 0 -> all 0xB6.
- Transpose: in_state byte n=1 = 0x01, other bytes 0x00, key = 0 -> out byte n=8 = 0xEE, all others 0xFC. Byte n=2 = 0x02 -> out byte n=16 = 0xDD.
- Backpressure: hold out_ready = 0, push tags 1,2,3 back-to-back.
  - Required: tags 1,2 accepted; in_ready = 0 from the third cycle; out_state/out_tag stable.
  - Then release out_ready: outputs 1,2,3 in order, no duplicates.
- Streaming: 16 random vectors with out_ready toggled pseudo-randomly -> every output matches a reference model X/S/P in order, tags match.
- Reset mid-operation: rst asserted for 1 cycle while both stages are full and stalled -> next cycle out_valid = 0, out_state = 0, in_ready = 1. A new input then emerges after 2 cycles, uncorrupted.
